// File: rtl/game_flow_controller_if.sv
// Signal bundle between the game flow controller and its surroundings:
// raw inputs, live processor outputs, and the frame-stable copies for the renderer.
interface game_flow_controller_if;
    logic        button_n;
    logic        vga_vs;
    logic [31:0] bird_y_in;
    logic [31:0] pipe1_x_in;
    logic [31:0] pipe1_y_in;
    logic [31:0] pipe2_x_in;
    logic [31:0] pipe2_y_in;
    logic        gameover_in;
    logic [31:0] score_in;
    logic        proc_hold;
    logic        flap_pulse;
    logic        frame_tick;
    logic [31:0] bird_y;
    logic [31:0] pipe1_x;
    logic [31:0] pipe1_y;
    logic [31:0] pipe2_x;
    logic [31:0] pipe2_y;
    logic        gameover_out;
    logic [31:0] score_out;
    logic [1:0]  game_state;

    modport slave (
        input  button_n, vga_vs, bird_y_in, pipe1_x_in, pipe1_y_in, pipe2_x_in,
               pipe2_y_in, gameover_in, score_in,
        output proc_hold, flap_pulse, frame_tick, bird_y, pipe1_x, pipe1_y,
               pipe2_x, pipe2_y, gameover_out, score_out, game_state
    );

    modport master (
        output button_n, vga_vs, bird_y_in, pipe1_x_in, pipe1_y_in, pipe2_x_in,
               pipe2_y_in, gameover_in, score_in,
        input  proc_hold, flap_pulse, frame_tick, bird_y, pipe1_x, pipe1_y,
               pipe2_x, pipe2_y, gameover_out, score_out, game_state
    );
endinterface

// File: rtl/game_flow_controller.sv
// Flappy Bird game sequencer: button debounce, IDLE/PLAY/OVER flow, processor hold
// and flap forwarding, and per-frame snapshots of the processor outputs for VGA.
module game_flow_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DB_W            = 20,
    parameter int unsigned HOLDOFF_FRAMES  = 60,
    parameter int unsigned HF_W            = 8
) (
    input logic clock,
    input logic resetn,
    game_flow_controller_if.slave gf
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    state_t          state;
    logic            btn_meta, btn_sync, db_level, press;
    logic [DB_W-1:0] db_cnt;
    logic            vs_meta, vs_sync, vs_last;
    logic [HF_W-1:0] holdoff;
    logic            frame_load;

    // Falling edge of synchronized vsync; drives both frame_tick and the snapshot load.
    assign frame_load    = vs_last & ~vs_sync;
    assign gf.game_state = state;

    // Button is inverted on entry so every internal level reads 1 = pressed.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            db_level <= 1'b0;
            db_cnt   <= '0;
            press    <= 1'b0;
            vs_meta  <= 1'b0;
            vs_sync  <= 1'b0;
            vs_last  <= 1'b0;
        end else begin
            btn_meta <= ~gf.button_n;
            btn_sync <= btn_meta;
            vs_meta  <= gf.vga_vs;
            vs_sync  <= vs_meta;
            vs_last  <= vs_sync;
            press    <= 1'b0;
            if (btn_sync != db_level) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level <= btn_sync;
                    db_cnt   <= '0;
                    press    <= btn_sync;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            gf.frame_tick   <= 1'b0;
            gf.bird_y       <= '0;
            gf.pipe1_x      <= '0;
            gf.pipe1_y      <= '0;
            gf.pipe2_x      <= '0;
            gf.pipe2_y      <= '0;
            gf.gameover_out <= 1'b0;
            gf.score_out    <= '0;
        end else begin
            gf.frame_tick <= frame_load;
            if (frame_load) begin
                gf.bird_y       <= gf.bird_y_in;
                gf.pipe1_x      <= gf.pipe1_x_in;
                gf.pipe1_y      <= gf.pipe1_y_in;
                gf.pipe2_x      <= gf.pipe2_x_in;
                gf.pipe2_y      <= gf.pipe2_y_in;
                gf.gameover_out <= gf.gameover_in;
                gf.score_out    <= gf.score_in;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            gf.proc_hold  <= 1'b1;
            gf.flap_pulse <= 1'b0;
            holdoff       <= '0;
        end else begin
            gf.flap_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    gf.proc_hold <= 1'b1;
                    if (press) begin
                        state        <= PLAY;
                        gf.proc_hold <= 1'b0;
                    end
                end
                PLAY: begin
                    // A game-over load in the same cycle as a press swallows the flap.
                    if (frame_load && gf.gameover_in) begin
                        state   <= OVER;
                        holdoff <= '0;
                    end else begin
                        gf.flap_pulse <= press;
                    end
                end
                OVER: begin
                    if (press && holdoff == HF_W'(HOLDOFF_FRAMES)) begin
                        state        <= IDLE;
                        gf.proc_hold <= 1'b1;
                    end
                    if (frame_load && holdoff != HF_W'(HOLDOFF_FRAMES))
                        holdoff <= holdoff + 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    gf.proc_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with a short debounce and hold-off.
module tb_game_flow_controller;

    logic clock;
    logic resetn;
    int   n_checks;
    int   n_fail;
    int   flap_count;
    int   flap_run;
    int   flap_max;
    int   bad_flap;
    int   lat;
    int   ticks;

    game_flow_controller_if gf();

    game_flow_controller #(
        .DEBOUNCE_CYCLES(4),
        .DB_W(20),
        .HOLDOFF_FRAMES(2),
        .HF_W(8)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .gf(gf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (resetn && gf.flap_pulse) begin
            flap_count = flap_count + 1;
            flap_run   = flap_run + 1;
            if (flap_run > flap_max) flap_max = flap_run;
            if (gf.game_state != 2'b01) bad_flap = bad_flap + 1;
        end else begin
            flap_run = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks = n_checks + 1;
        if (actual !== expected) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drops vsync, measures the frame_tick latency and width, then restores vsync.
    task automatic do_frame(output int latency, output int tick_cnt);
        latency  = 0;
        tick_cnt = 0;
        gf.vga_vs = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (gf.frame_tick) begin
                tick_cnt = tick_cnt + 1;
                if (latency == 0) latency = i;
            end
        end
        gf.vga_vs = 1'b1;
        wait_cycles(4);
    endtask

    task automatic press_release(input int low_cycles, input int high_cycles);
        gf.button_n = 1'b0;
        wait_cycles(low_cycles);
        gf.button_n = 1'b1;
        wait_cycles(high_cycles);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        flap_count = 0;
        flap_run   = 0;
        flap_max   = 0;
        bad_flap   = 0;
        resetn         = 1'b0;
        gf.button_n    = 1'b1;
        gf.vga_vs      = 1'b1;
        gf.bird_y_in   = 32'd0;
        gf.pipe1_x_in  = 32'd0;
        gf.pipe1_y_in  = 32'd0;
        gf.pipe2_x_in  = 32'd0;
        gf.pipe2_y_in  = 32'd0;
        gf.gameover_in = 1'b0;
        gf.score_in    = 32'd0;

        wait_cycles(3);
        check_eq("rst_state", 32'(gf.game_state), 32'd0);
        check_eq("rst_hold", 32'(gf.proc_hold), 32'd1);
        check_eq("rst_flap", 32'(gf.flap_pulse), 32'd0);
        check_eq("rst_tick", 32'(gf.frame_tick), 32'd0);
        check_eq("rst_bird_y", gf.bird_y, 32'd0);
        resetn = 1'b1;
        wait_cycles(6);

        // Frame latching while IDLE
        gf.bird_y_in  = 32'd5;
        gf.pipe1_x_in = 32'd120;
        gf.pipe2_y_in = 32'hFFFF_0001;
        gf.score_in   = 32'hDEAD_BEEF;
        do_frame(lat, ticks);
        check_eq("tick_latency", 32'(lat), 32'd3);
        check_eq("tick_width", 32'(ticks), 32'd1);
        check_eq("snap_bird_y", gf.bird_y, 32'd5);
        check_eq("snap_pipe1_x", gf.pipe1_x, 32'd120);
        check_eq("snap_pipe2_y", gf.pipe2_y, 32'hFFFF_0001);
        check_eq("snap_score", gf.score_out, 32'hDEAD_BEEF);
        gf.bird_y_in = 32'd9;
        wait_cycles(5);
        check_eq("midframe_bird_y", gf.bird_y, 32'd5);
        do_frame(lat, ticks);
        check_eq("tick_latency2", 32'(lat), 32'd3);
        check_eq("newframe_bird_y", gf.bird_y, 32'd9);
        check_eq("idle_still", 32'(gf.game_state), 32'd0);

        // Bounce rejection then a clean hold starts play
        for (int i = 0; i < 10; i++) begin
            gf.button_n = ~gf.button_n;
            wait_cycles(2);
        end
        check_eq("bounce_idle", 32'(gf.game_state), 32'd0);
        check_eq("bounce_hold", 32'(gf.proc_hold), 32'd1);
        gf.button_n = 1'b0;
        wait_cycles(10);
        check_eq("start_state", 32'(gf.game_state), 32'd1);
        check_eq("start_hold", 32'(gf.proc_hold), 32'd0);
        gf.button_n = 1'b1;
        wait_cycles(12);
        check_eq("start_no_flap", 32'(flap_count), 32'd0);
        check_eq("release_state", 32'(gf.game_state), 32'd1);

        // Flap forwarding: two presses 50 cycles apart
        press_release(10, 10);
        check_eq("flap_one", 32'(flap_count), 32'd1);
        wait_cycles(30);
        press_release(10, 10);
        check_eq("flap_two", 32'(flap_count), 32'd2);
        check_eq("flap_width", 32'(flap_max), 32'd1);
        do_frame(lat, ticks);
        check_eq("play_frame_state", 32'(gf.game_state), 32'd1);

        // Game over load coincides with a press
        gf.gameover_in = 1'b1;
        gf.button_n = 1'b0;
        wait_cycles(4);
        gf.vga_vs = 1'b0;
        wait_cycles(6);
        check_eq("over_state", 32'(gf.game_state), 32'd2);
        check_eq("over_no_flap", 32'(flap_count), 32'd2);
        check_eq("over_flag", 32'(gf.gameover_out), 32'd1);
        check_eq("over_hold", 32'(gf.proc_hold), 32'd0);
        gf.vga_vs = 1'b1;
        gf.button_n = 1'b1;
        wait_cycles(12);

        // Hold-off: press after one frame ignored, after two frames accepted
        do_frame(lat, ticks);
        press_release(10, 12);
        check_eq("holdoff_ignore", 32'(gf.game_state), 32'd2);
        do_frame(lat, ticks);
        gf.button_n = 1'b0;
        wait_cycles(10);
        check_eq("holdoff_idle", 32'(gf.game_state), 32'd0);
        check_eq("holdoff_hold", 32'(gf.proc_hold), 32'd1);
        gf.button_n = 1'b1;
        wait_cycles(20);
        check_eq("no_phantom_play", 32'(gf.game_state), 32'd0);
        check_eq("flap_total", 32'(flap_count), 32'd2);
        check_eq("flap_only_play", 32'(bad_flap), 32'd0);

        // Asynchronous reset mid-PLAY
        gf.gameover_in = 1'b0;
        press_release(10, 12);
        check_eq("replay_state", 32'(gf.game_state), 32'd1);
        check_eq("replay_bird_y", gf.bird_y, 32'd9);
        #2 resetn = 1'b0;
        #1;
        check_eq("async_rst_state", 32'(gf.game_state), 32'd0);
        check_eq("async_rst_hold", 32'(gf.proc_hold), 32'd1);
        check_eq("async_rst_bird_y", gf.bird_y, 32'd0);
        check_eq("async_rst_over", 32'(gf.gameover_out), 32'd0);
        check_eq("async_rst_score", gf.score_out, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        wait_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
